// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
// Holds the receiver state encoding, default clock/baud and a bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_BAUD     = 9600;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with a configurable reset level.
// Ports: clk, rst (sync, active-high), d_i (async input), q_o (synchronized output).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: samples rxd mid-bit and presents each good byte with a rdone strobe.
// Ports: clk, rst (sync, active-high), rxd (async serial in), rxddata[7:0], rdone;
// ferr (framing-error pulse) only when UART_RX_FERR_EN is defined.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rxddata,
    output logic       rdone
`ifdef UART_RX_FERR_EN
    ,
    output logic       ferr
`endif
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1    = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_receiver: CLKS_PER_BIT must be >= 4");
    end

    logic rxd_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rxd),
        .q_o(rxd_s)
    );

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          rdone_q, rdone_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            rdone_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            rdone_q  <= rdone_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        rdone_d  = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    // A start bit that is no longer low mid-bit was noise.
                    state_d  = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d             = '0;
                    shreg_d[bitidx_q] = rxd_s;
                    if (bitidx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        data_d  = shreg_q;
                        rdone_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign rxddata = data_q;
    assign rdone   = rdone_q;

`ifdef UART_RX_FERR_EN
    assign ferr = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
// Build with UART_RX_FERR_EN to also cover the ferr port.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rxddata;
    logic       rdone;
`ifdef UART_RX_FERR_EN
    logic       ferr;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int n_rdone  = 0;
    int n_ferr   = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ(100_000_000),
        .BAUD(6_250_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .rxddata(rxddata),
        .rdone(rdone)
`ifdef UART_RX_FERR_EN
        ,
        .ferr(ferr)
`endif
    );

    always @(negedge clk) begin
        if (rdone === 1'b1) begin
            n_rdone++;
            got_q.push_back(rxddata);
        end
`ifdef UART_RX_FERR_EN
        if (ferr === 1'b1) n_ferr++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    int base;
    int fbase;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_rxddata", 32'(rxddata), 32'h00);
        check("rst_rdone", 32'(rdone), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // start glitch shorter than half a bit
        base = n_rdone;
        hold(1'b0, 3);
        hold(1'b1, 2 * CPB);
        check("glitch_rdone", 32'(n_rdone - base), 32'd0);
        check("glitch_data", 32'(rxddata), 32'h00);

        // long idle line
        base = n_rdone;
        hold(1'b1, 20 * CPB);
        check("idle_rdone", 32'(n_rdone - base), 32'd0);
        check("idle_state", 32'(dut.state_q), 32'(IDLE));

        // single frame
        base = n_rdone;
        send(8'hA5, 1'b1);
        hold(1'b1, 2 * CPB);
        check("a5_pulses", 32'(n_rdone - base), 32'd1);
        check("a5_byte", 32'(got_q[base]), 32'hA5);
        check("a5_hold", 32'(rxddata), 32'hA5);

        // back-to-back frames
        base = n_rdone;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 2 * CPB);
        check("b2b_pulses", 32'(n_rdone - base), 32'd2);
        check("b2b_first", 32'(got_q[base]), 32'h00);
        check("b2b_second", 32'(got_q[base+1]), 32'hFF);
        check("b2b_hold", 32'(rxddata), 32'hFF);

        // framing error
        base  = n_rdone;
        fbase = n_ferr;
        send(8'h3C, 1'b0);
        hold(1'b1, 3 * CPB);
        check("ferr_rdone", 32'(n_rdone - base), 32'd0);
        check("ferr_data", 32'(rxddata), 32'hFF);
`ifdef UART_RX_FERR_EN
        check("ferr_pulse", 32'(n_ferr - fbase), 32'd1);
`endif

        // reset during data bit 4 of 0x55
        base = n_rdone;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, CPB);
        hold(1'b1, CPB / 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_data", 32'(rxddata), 32'h00);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        hold(1'b1, 4 * CPB);
        send(8'h81, 1'b1);
        hold(1'b1, 2 * CPB);
        check("mrst_pulses", 32'(n_rdone - base), 32'd1);
        check("mrst_byte", 32'(rxddata), 32'h81);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
